spu32_cpu_lsu: RTL
==================

// Module: spu32_cpu_lsu
// PURPOSE
//  Load/store unit consuming the bus operation codes (BUSOP_*) the decoder emits for LOAD/STORE.
//  Executes each access on an 8-bit Wishbone-classic master port, one byte cycle at a time.
//  Loads are assembled little-endian, then sign- or zero-extended; stores are split into bytes.
//  Sits between the CPU control FSM and the system bus; misaligned accesses are legal.
// PARAMETERS
//  ADR_W    32  bus address width; addresses wrap modulo 2^ADR_W
//  TIMEOUT  0   max cycles to wait for ack per byte; 0 = wait forever
// PORTS
//  I_clk       in   1      clock; all state on rising edge
//  I_reset_n   in   1      asynchronous active-low reset
//  I_en        in   1      start strobe; sampled only when O_busy=0
//  I_op        in   3      BUSOP_READB/READH/READW/READBU/READHU/WRITEB/WRITEH/WRITEW
//  I_addr      in   ADR_W  byte address of first byte
//  I_data      in   32     store data; byte k = I_data[8k+7:8k]
//  O_data      out  32     load result, valid when O_done=1 and O_err=0
//  O_busy      out  1      high from the cycle after acceptance until O_done
//  O_done      out  1      one-cycle completion pulse
//  O_err       out  1      one-cycle pulse with O_done on timeout abort
//  O_wb_cyc    out  1      bus cycle active
//  O_wb_stb    out  1      byte strobe
//  O_wb_we     out  1      1 = write
//  O_wb_adr    out  ADR_W  current byte address
//  O_wb_dat    out  8      write byte
//  I_wb_dat    in   8      read byte, sampled on ack
//  I_wb_ack    in   1      byte-cycle acknowledge
// BEHAVIOUR
//  - Reset (async, any state): all outputs 0; FSM->IDLE; byte counter, wait counter, data regs 0.
//  - FSM: IDLE -> XFER on I_en; XFER -> DONE on last ack or timeout; DONE -> IDLE unconditionally.
//  - IDLE: on I_en latch op, addr, data; byte count N = 1 (B/BU), 2 (H/HU), 4 (W).
//  - Undefined I_op encodings behave as READW.
//  - XFER: cyc=stb=1, we per op, adr = base + k (mod 2^ADR_W), dat = store byte k.
//  - On ack with k<N-1: capture byte k; k+1; stb stays high; new adr/dat on the next cycle.
//  - On ack with k=N-1: capture the byte; go to DONE. cyc/stb/we are 0 in DONE.
//  - DONE: O_done=1 for exactly one cycle, O_busy=0. O_data holds the load result.
//  - READB/READH: sign-extend from bit 7/15. READBU/READHU: zero-extend.
//  - Writes leave O_data unchanged.
//  - Latency, zero-wait slave: accept at edge T, stb high during T+1..T+N, O_done in cycle T+N+1.
//  - I_en while O_busy=1 or in DONE: ignored, with no queuing.
//  - I_wb_ack while stb=0: ignored.
//  - TIMEOUT>0: the wait counter clears on each new byte.
//  - If the wait counter reaches TIMEOUT cycles without ack: abort to DONE, pulse O_err, O_data=0.
//  - Bytes already written on an aborted store stay written (no rollback).
//  - Wait counter width is $clog2(TIMEOUT+1). TIMEOUT=0 removes the counter logic.
//  - Reset deasserted mid-transfer: next cycle starts in IDLE, no stale stb, no O_done.
// TESTING
//  - READB addr 0x100, slave returns 0x80 zero-wait -> stb 1 cycle, adr 0x100, O_data=0xFFFFFF80.
//  - READBU, same setup -> O_data=0x00000080.
//  - READW addr 0x203 (misaligned), bytes 11,22,33,44 at 0x203..0x206 -> O_data=0x44332211.
//  - READW timing: O_done at T+5.
//  - WRITEH addr 0xFFFFFFFF, I_data=0xAABBCCDD -> bytes DD@0xFFFFFFFF, CC@0x00000000 (wrap).
//  - WRITEH: we=1 on both byte cycles, O_data unchanged.
//  - READH with 3 wait states per byte, I_en re-pulsed while busy -> 8 stb cycles, single O_done.
//  - READH: the re-pulsed I_en is ignored.
//  - TIMEOUT=4, no ack -> cyc drops after 4 cycles; O_done=O_err=1 for one cycle; O_data=0.
//  - I_reset_n low mid-READW (after byte 1) -> cyc/stb/busy 0 immediately, no O_done.
//  - After that reset, a next READB completes normally.

Source files
------------

// File: rtl/spu32_cpu_lsu_if.sv
// spu32_cpu_lsu_if: bundles the CPU-side request/response signals and the 8-bit
// Wishbone-classic master port of the load/store unit.
//   master modport : seen from the LSU (drives O_*, receives I_*)
//   slave modport  : seen from the CPU/bus environment
// Signals:
//   I_en, I_op[2:0], I_addr, I_data[31:0]  request (start strobe, BUSOP code, address, store data)
//   O_data[31:0], O_busy, O_done, O_err    response (load result, busy, done pulse, abort pulse)
//   O_wb_cyc, O_wb_stb, O_wb_we, O_wb_adr, O_wb_dat[7:0], I_wb_dat[7:0], I_wb_ack  byte bus
interface spu32_cpu_lsu_if #(
    parameter int unsigned ADR_W = 32
) ();
    logic             I_en;
    logic [2:0]       I_op;
    logic [ADR_W-1:0] I_addr;
    logic [31:0]      I_data;
    logic [31:0]      O_data;
    logic             O_busy;
    logic             O_done;
    logic             O_err;
    logic             O_wb_cyc;
    logic             O_wb_stb;
    logic             O_wb_we;
    logic [ADR_W-1:0] O_wb_adr;
    logic [7:0]       O_wb_dat;
    logic [7:0]       I_wb_dat;
    logic             I_wb_ack;

    modport master (
        input  I_en, I_op, I_addr, I_data, I_wb_dat, I_wb_ack,
        output O_data, O_busy, O_done, O_err, O_wb_cyc, O_wb_stb, O_wb_we, O_wb_adr, O_wb_dat
    );

    modport slave (
        output I_en, I_op, I_addr, I_data, I_wb_dat, I_wb_ack,
        input  O_data, O_busy, O_done, O_err, O_wb_cyc, O_wb_stb, O_wb_we, O_wb_adr, O_wb_dat
    );
endinterface

// File: rtl/spu32_cpu_lsu.sv
// spu32_cpu_lsu: load/store unit executing BUSOP_* accesses one byte at a time on an
// 8-bit Wishbone-classic master port. Loads are assembled little-endian and sign- or
// zero-extended; stores are split into bytes. Misaligned addresses are legal and wrap.
// Ports:
//   I_clk      clock, rising edge
//   I_reset_n  asynchronous active-low reset
//   bus        spu32_cpu_lsu_if.master (CPU request/response + Wishbone byte port)
// Parameters:
//   ADR_W      bus address width
//   TIMEOUT    max cycles to wait for ack per byte, 0 = wait forever
module spu32_cpu_lsu #(
    parameter int unsigned ADR_W   = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input logic             I_clk,
    input logic             I_reset_n,
    spu32_cpu_lsu_if.master bus
);
    localparam logic [2:0] BUSOP_READB  = 3'b000;
    localparam logic [2:0] BUSOP_READBU = 3'b001;
    localparam logic [2:0] BUSOP_READH  = 3'b010;
    localparam logic [2:0] BUSOP_READHU = 3'b011;
    localparam logic [2:0] BUSOP_READW  = 3'b100;
    localparam logic [2:0] BUSOP_WRITEB = 3'b101;
    localparam logic [2:0] BUSOP_WRITEH = 3'b110;
    localparam logic [2:0] BUSOP_WRITEW = 3'b111;

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [ADR_W-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rbuf_q, rbuf_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       idx_q, idx_d;
    logic             err_q, err_d;

    logic [1:0]       last_idx;
    logic             is_write;
    logic             xfer_ack;
    logic             last_ack;
    logic             timeout;
    logic [31:0]      assembled;
    logic [31:0]      load_result;

    // Operation decode of the latched op.
    always_comb begin
        last_idx = 2'd3;
        is_write = 1'b0;
        case (op_q)
            BUSOP_READB, BUSOP_READBU: last_idx = 2'd0;
            BUSOP_READH, BUSOP_READHU: last_idx = 2'd1;
            BUSOP_WRITEB: begin
                last_idx = 2'd0;
                is_write = 1'b1;
            end
            BUSOP_WRITEH: begin
                last_idx = 2'd1;
                is_write = 1'b1;
            end
            BUSOP_WRITEW: is_write = 1'b1;
            default:      last_idx = 2'd3;
        endcase
    end

    assign xfer_ack = (state_q == StXfer) && bus.I_wb_ack;
    assign last_ack = xfer_ack && (idx_q == last_idx);

    // Per-byte ack wait counter; an ack in the final allowed cycle still wins.
    if (TIMEOUT > 0) begin : g_timeout
        localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
        logic [WaitW-1:0] wait_q, wait_d;

        always_comb begin
            wait_d = wait_q;
            if (state_q != StXfer || bus.I_wb_ack) begin
                wait_d = '0;
            end else begin
                wait_d = wait_q + WaitW'(1);
            end
        end

        assign timeout = (state_q == StXfer) && !bus.I_wb_ack &&
                         (wait_q == WaitW'(TIMEOUT - 1));

        always_ff @(posedge I_clk or negedge I_reset_n) begin
            if (!I_reset_n) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_d;
            end
        end
    end else begin : g_no_timeout
        assign timeout = 1'b0;
    end

    // State register.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.I_en) state_d = StXfer;
            StXfer: if (last_ack || timeout) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: request latch, byte capture and load extension.
    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        data_d  = data_q;
        idx_d   = idx_q;
        err_d   = 1'b0;

        assembled = rbuf_q;
        assembled[{idx_q, 3'b000} +: 8] = bus.I_wb_dat;

        case (op_q)
            BUSOP_READB:  load_result = {{24{assembled[7]}}, assembled[7:0]};
            BUSOP_READBU: load_result = {24'h0, assembled[7:0]};
            BUSOP_READH:  load_result = {{16{assembled[15]}}, assembled[15:0]};
            BUSOP_READHU: load_result = {16'h0, assembled[15:0]};
            default:      load_result = assembled;
        endcase

        if (state_q == StIdle && bus.I_en) begin
            op_d    = bus.I_op;
            addr_d  = bus.I_addr;
            wdata_d = bus.I_data;
            rbuf_d  = '0;
            idx_d   = '0;
        end else if (xfer_ack) begin
            rbuf_d = assembled;
            if (idx_q == last_idx) begin
                if (!is_write) data_d = load_result;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else if (timeout) begin
            data_d = '0;
            err_d  = 1'b1;
        end
    end

    // Outputs, decoded from registered state only.
    always_comb begin
        bus.O_wb_cyc = (state_q == StXfer);
        bus.O_wb_stb = (state_q == StXfer);
        bus.O_wb_we  = (state_q == StXfer) && is_write;
        bus.O_wb_adr = addr_q + ADR_W'(idx_q);
        bus.O_wb_dat = wdata_q[{idx_q, 3'b000} +: 8];
        bus.O_busy   = (state_q == StXfer);
        bus.O_done   = (state_q == StDone);
        bus.O_err    = err_q;
        bus.O_data   = data_q;
    end
endmodule
